// File: rtl/snn_input_loader_pkg.sv
// Shared types and constants for the SNN input loader and the blocks that talk to it.
package snn_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, KICK, RUN} loader_state_t;

  localparam int NUM_PIXELS = 784;
  localparam int PIX_ADDR_W = 10;

endpackage

// File: rtl/snn_input_loader_if.sv
// Core-facing bus of the input loader: pixel read port plus start/done handshake.
// The timeout_err line only exists when SNN_LOADER_TIMEOUT_EN is defined.
interface snn_input_loader_if;
  import snn_pkg::*;

  logic [PIX_ADDR_W-1:0] addr_input_unit;
  logic                  q_input;
  logic                  start;
  logic                  done;
  logic                  busy;
  logic                  overrun;
`ifdef SNN_LOADER_TIMEOUT_EN
  logic                  timeout_err;
`endif

  // master is the classifier core, slave is the loader
  modport master (
`ifdef SNN_LOADER_TIMEOUT_EN
    input  timeout_err,
`endif
    output addr_input_unit, done,
    input  q_input, start, busy, overrun
  );

  modport slave (
`ifdef SNN_LOADER_TIMEOUT_EN
    output timeout_err,
`endif
    input  addr_input_unit, done,
    output q_input, start, busy, overrun
  );

endinterface

// File: rtl/snn_input_loader_uart_rx.sv
// Generic 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB first.
// rx_rdy pulses for one cycle with rx_data valid; framing errors are dropped silently.
module uart_rx #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rxMeta_q, rxSync_q, rxPrev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rdy_q, rdy_d;

  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q + 1'b1;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    rdy_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baudCnt_d = '0;
        if (rxPrev_q && !rxSync_q) state_d = S_START;
      end
      S_START: begin
        // a start bit that is high again at mid-bit was only a glitch
        if (baudCnt_q == HALF_M1) begin
          baudCnt_d = '0;
          bitIdx_d  = 3'd0;
          state_d   = rxSync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baudCnt_q == FULL_M1) begin
          baudCnt_d = '0;
          shift_d   = {rxSync_q, shift_q[7:1]};
          bitIdx_d  = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = S_STOP;
        end
      end
      default: begin
        if (baudCnt_q == FULL_M1) begin
          baudCnt_d = '0;
          rdy_d     = rxSync_q;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxPrev_q  <= 1'b1;
      state_q   <= S_IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= 3'd0;
      shift_q   <= 8'h00;
      rdy_q     <= 1'b0;
    end else begin
      rxMeta_q  <= rx;
      rxSync_q  <= rxMeta_q;
      rxPrev_q  <= rxSync_q;
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      rdy_q     <= rdy_d;
    end
  end

  assign rx_data = shift_q;
  assign rx_rdy  = rdy_q;

endmodule

// File: rtl/snn_input_loader.sv
// Loads a packed 28x28 binary image from UART into pixel memory and hands it to the SNN core.
// Define SNN_LOADER_TIMEOUT_EN to abandon frames that stall for TIMEOUT_CLKS and pulse timeout_err.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int NUM_BYTES    = 98,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  snn_input_loader_if.slave  bus
);

  localparam int WORD_W = PIX_ADDR_W - 3;
  localparam logic [WORD_W-1:0]     LAST_WORD = WORD_W'(NUM_BYTES - 1);
  localparam logic [PIX_ADDR_W-1:0] PIX_LIMIT = PIX_ADDR_W'(8 * NUM_BYTES);

  logic [7:0]        rxData;
  logic              rxRdy;
  loader_state_t     state_q, state_d;
  logic [WORD_W-1:0] wordCnt_q, wordCnt_d;
  logic              overrun_q, overrun_d;
  logic              qInput_q;
  logic              memWe;
  logic [WORD_W-1:0] memWAddr;
  logic [WORD_W-1:0] rdWord;
  logic              rdValid;
  logic [7:0]        mem [NUM_BYTES];
`ifdef SNN_LOADER_TIMEOUT_EN
  logic [20:0]       idleCnt_q, idleCnt_d;
  logic              timeoutErr_q, timeoutErr_d;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_data (rxData),
    .rx_rdy  (rxRdy)
  );

  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    overrun_d = overrun_q;
    memWe     = 1'b0;
    memWAddr  = wordCnt_q;
`ifdef SNN_LOADER_TIMEOUT_EN
    idleCnt_d    = '0;
    timeoutErr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rxRdy) begin
          memWe     = 1'b1;
          memWAddr  = '0;
          wordCnt_d = WORD_W'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (rxRdy) begin
          memWe = 1'b1;
          if (wordCnt_q == LAST_WORD) begin
            wordCnt_d = '0;
            state_d   = KICK;
          end else begin
            wordCnt_d = wordCnt_q + 1'b1;
          end
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        else if (idleCnt_q == 21'(TIMEOUT_CLKS)) begin
          wordCnt_d    = '0;
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          idleCnt_d = idleCnt_q + 21'd1;
        end
`endif
      end
      KICK: begin
        overrun_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        // memory is owned by the core here, so late bytes are only flagged
        if (rxRdy) overrun_d = 1'b1;
        if (bus.done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wordCnt_q <= '0;
      overrun_q <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
      idleCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      overrun_q <= overrun_d;
`ifdef SNN_LOADER_TIMEOUT_EN
      idleCnt_q    <= idleCnt_d;
      timeoutErr_q <= timeoutErr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memWAddr] <= rxData;
  end

  // out-of-range addresses are steered to word 0 and masked to zero
  assign rdValid = (bus.addr_input_unit < PIX_LIMIT);
  assign rdWord  = rdValid ? bus.addr_input_unit[PIX_ADDR_W-1:3] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qInput_q <= 1'b0;
    else        qInput_q <= rdValid & mem[rdWord][bus.addr_input_unit[2:0]];
  end

  assign bus.q_input = qInput_q;
  assign bus.start   = (state_q == KICK);
  assign bus.busy    = (state_q != IDLE);
  assign bus.overrun = overrun_q;
`ifdef SNN_LOADER_TIMEOUT_EN
  assign bus.timeout_err = timeoutErr_q;
`endif

endmodule
